// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_pkg
// Description : Shared constants for the pio_edge_irq slice: register word
//               addresses and the capture-edge encodings used by EDGE_TYPE.
// Revision    : 1.0  initial release
// ============================================================================
package pio_pkg;

  // Register word addresses
  localparam logic [2:0] PIO_ADDR_DATA    = 3'd0;
  localparam logic [2:0] PIO_ADDR_OUT     = 3'd1;
  localparam logic [2:0] PIO_ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] PIO_ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] PIO_ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] PIO_ADDR_OUTCLR  = 3'd5;

  // Capture-edge encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage
`default_nettype wire

// File: rtl/pio_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pio_sync_edge
// Description : Two-flop synchroniser for asynchronous inputs, a "previous"
//               flop and per-bit edge detection selected by EDGE_TYPE.
// Ports       : clk     in  1      clock
//               rst_n   in  1      asynchronous active-low reset
//               i_in    in  WIDTH  asynchronous inputs
//               o_sync  out WIDTH  synchronised inputs
//               o_edge  out WIDTH  one-cycle edge vector (in_sync vs prev)
// Revision    : 1.0  initial release
// ============================================================================
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev;

  // prev resets to 0, so an input held high through reset shows as a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= i_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;

  generate
    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
      assign o_edge = r_sync & ~r_prev;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign o_edge = ~r_sync & r_prev;
    end else begin : g_any
      assign o_edge = r_sync ^ r_prev;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pio_edge_irq.sv
`default_nettype none
// ============================================================================
// Module      : pio_edge_irq
// Description : Parametrised Avalon-MM PIO slave: output register, synchronised
//               inputs, per-bit edge capture and a maskable level interrupt.
//               Optional macro PIO_OUTSETCLR_EN enables atomic set (addr 4) and
//               clear (addr 5) of the output register; otherwise those
//               addresses are reserved.
// Ports       : clk, reset_n (async active-low), address[2:0], chipselect,
//               write_n, writedata[31:0], readdata[31:0] (combinational),
//               in_port[WIDTH], out_port[WIDTH], irq (registered level)
// Revision    : 1.0  initial release
// ============================================================================
module pio_edge_irq
  import pio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic             w_unused_wd;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_out_nxt;
  logic [31:0]      w_rdata;

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic             r_irq;

  assign w_wr        = chipselect & ~write_n;
  assign w_wd        = writedata[WIDTH-1:0];
  assign w_unused_wd = ^writedata;

  pio_sync_edge #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_in   (in_port),
    .o_sync (w_sync),
    .o_edge (w_edge)
  );

  // Write-1-to-clear mask; a fresh edge in the same cycle still sets the bit.
  assign w_clr = (w_wr && (address == PIO_ADDR_EDGECAP)) ? w_wd : '0;

  always_comb begin
    w_out_nxt = r_out;
    if (w_wr) begin
      case (address)
        PIO_ADDR_OUT:    w_out_nxt = w_wd;
`ifdef PIO_OUTSETCLR_EN
        PIO_ADDR_OUTSET: w_out_nxt = r_out | w_wd;
        PIO_ADDR_OUTCLR: w_out_nxt = r_out & ~w_wd;
`endif
        default:         w_out_nxt = r_out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out  <= RESET_VALUE;
      r_mask <= '0;
      r_cap  <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_out <= w_out_nxt;
      if (w_wr && (address == PIO_ADDR_IRQMASK)) begin
        r_mask <= w_wd;
      end
      r_cap <= (r_cap & ~w_clr) | w_edge;
      // Built from the current register values, so a clear/mask write
      // drops irq one cycle after the write edge.
      r_irq <= |(r_cap & r_mask);
    end
  end

  // Zero-wait-state read mux; independent of chipselect.
  always_comb begin
    w_rdata = '0;
    case (address)
      PIO_ADDR_DATA:    w_rdata[WIDTH-1:0] = w_sync;
      PIO_ADDR_OUT:     w_rdata[WIDTH-1:0] = r_out;
      PIO_ADDR_IRQMASK: w_rdata[WIDTH-1:0] = r_mask;
      PIO_ADDR_EDGECAP: w_rdata[WIDTH-1:0] = r_cap;
      default:          w_rdata = '0;
    endcase
  end

  assign readdata = w_rdata;
  assign out_port = r_out;
  assign irq      = r_irq;

endmodule
`default_nettype wire
